// File: rtl/uart_sram_read_bridge_if.sv
// ---------------------------------------------------------------------------
// uart_sram_read_bridge_if
// Bundles the UART command-bus read handshake and the SRAM read port seen by
// uart_sram_read_bridge.
//   uart_address/uart_read/uart_req : request from the bus master
//   uart_gnt                        : bridge idle, request may be accepted
//   uart_rd_data/uart_rd_valid      : returned byte + one-cycle strobe
//   sram_address/sram_read_enable   : registered SRAM read address + enable
//   sram_read_data                  : byte coming back from the SRAM
// The master modport is the environment side (bus master plus SRAM data
// source); the slave modport is the bridge side.
// ---------------------------------------------------------------------------
interface uart_sram_read_bridge_if;
    logic [15:0] uart_address;
    logic        uart_read;
    logic        uart_req;
    logic        uart_gnt;
    logic [7:0]  uart_rd_data;
    logic        uart_rd_valid;
    logic [9:0]  sram_address;
    logic        sram_read_enable;
    logic [7:0]  sram_read_data;

    modport master (
        output uart_address, uart_read, uart_req, sram_read_data,
        input  uart_gnt, uart_rd_data, uart_rd_valid, sram_address, sram_read_enable
    );

    modport slave (
        input  uart_address, uart_read, uart_req, sram_read_data,
        output uart_gnt, uart_rd_data, uart_rd_valid, sram_address, sram_read_enable
    );
endinterface

// File: rtl/uart_sram_read_bridge.sv
// ---------------------------------------------------------------------------
// uart_sram_read_bridge
// Read side of the UART-to-SRAM path. Accepts a read request when idle,
// registers the 10-bit SRAM address, waits READ_LATENCY clocks and returns
// the byte with a one-cycle valid strobe. Addresses with any of bits [15:10]
// set are outside the 1 KiB window and return OOR_DATA with identical timing.
// Ports:
//   clk50_dup : sole clock (rising edge)
//   rst       : asynchronous active-high reset
//   bus       : uart_sram_read_bridge_if.slave (UART handshake + SRAM read port)
// Parameters:
//   READ_LATENCY : clocks from registered address to valid SRAM data (>= 1)
//   LAT_W        : latency counter width, READ_LATENCY <= 2**LAT_W - 1
//   OOR_DATA     : byte returned for out-of-range addresses
// ---------------------------------------------------------------------------
module uart_sram_read_bridge #(
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned LAT_W        = 2,
    parameter logic [7:0]  OOR_DATA     = 8'h00
) (
    input  logic                    clk50_dup,
    input  logic                    rst,
    uart_sram_read_bridge_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [LAT_W-1:0] LAST_CNT = LAT_W'(READ_LATENCY - 1);

    state_t           state_q;
    logic [LAT_W-1:0] cnt_q;
    logic             oor_q;
    logic [7:0]       rd_data_q;
    logic [9:0]       sram_addr_q;
    // Status outputs are registered alongside the state so they carry no
    // combinational path from the inputs.
    logic             gnt_q;
    logic             valid_q;
    logic             ren_q;

    always_ff @(posedge clk50_dup or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            oor_q       <= 1'b0;
            rd_data_q   <= 8'h00;
            sram_addr_q <= 10'h000;
            gnt_q       <= 1'b1;
            valid_q     <= 1'b0;
            ren_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Write traffic (req without read) is never accepted here.
                    if (bus.uart_req && bus.uart_read && gnt_q) begin
                        state_q     <= WAIT;
                        sram_addr_q <= bus.uart_address[9:0];
                        oor_q       <= |bus.uart_address[15:10];
                        cnt_q       <= '0;
                        gnt_q       <= 1'b0;
                        ren_q       <= 1'b1;
                    end
                end
                WAIT: begin
                    // Counter stops at LAST_CNT, so it can never wrap.
                    if (cnt_q == LAST_CNT) begin
                        state_q   <= DONE;
                        rd_data_q <= oor_q ? OOR_DATA : bus.sram_read_data;
                        ren_q     <= 1'b0;
                        valid_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    gnt_q   <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b1;
                    valid_q <= 1'b0;
                    ren_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.uart_gnt         = gnt_q;
    assign bus.uart_rd_valid    = valid_q;
    assign bus.uart_rd_data     = rd_data_q;
    assign bus.sram_address     = sram_addr_q;
    assign bus.sram_read_enable = ren_q;
endmodule
